// File: rtl/param_traffic_light_controller.sv
// Highway / country-road intersection controller: parameterised dwell times,
// min/max country green with timeout pulse, and a night flashing mode.
module param_traffic_light_controller #(
  parameter int CNT_W    = 8,
  parameter int T_YEL    = 3,
  parameter int T_RED    = 2,
  parameter int T_HW_MIN = 8,
  parameter int T_CR_MIN = 2,
  parameter int T_CR_MAX = 16,
  parameter int T_FLASH  = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       X,
  input  logic       flash,
  output logic [1:0] HW,
  output logic [1:0] CR,
  output logic [2:0] state,
  output logic       cr_tmo
);

  typedef enum logic [2:0] {
    HW_G   = 3'd0,
    HW_Y   = 3'd1,
    AR1    = 3'd2,
    CR_G   = 3'd3,
    CR_Y   = 3'd4,
    AR2    = 3'd5,
    FLASH  = 3'd6,
    UNUSED = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    LAMP_RED = 2'b00,
    LAMP_YEL = 2'b01,
    LAMP_GRN = 2'b10,
    LAMP_OFF = 2'b11
  } lamp_e;

  // Dwell exit points: a state held T cycles leaves on the edge where timer == T-1.
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] HW_MIN_LAST = CNT_W'(T_HW_MIN - 1);
  localparam logic [CNT_W-1:0] CR_MIN_LAST = CNT_W'(T_CR_MIN - 1);
  localparam logic [CNT_W-1:0] CR_MAX_LAST = CNT_W'(T_CR_MAX - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             phase_q, phase_d;
  logic             cr_tmo_q, cr_tmo_d;
  lamp_e            hw_lamp, cr_lamp;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    timer_q  <= timer_d;
    phase_q  <= phase_d;
    cr_tmo_q <= cr_tmo_d;
  end

  // Next-state, dwell timer and blink phase.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    timer_d  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    phase_d  = phase_q;
    cr_tmo_d = 1'b0;

    if (clear) begin
      state_d = HW_G;
      phase_d = 1'b0;
    end else if (flash && state_q != FLASH) begin
      state_d = FLASH;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        HW_G: if (X && timer_q >= HW_MIN_LAST) state_d = HW_Y;
        HW_Y: if (timer_q == YEL_LAST)         state_d = AR1;
        AR1:  if (timer_q == RED_LAST)         state_d = CR_G;
        CR_G: begin
          if ((!X && timer_q >= CR_MIN_LAST) || timer_q == CR_MAX_LAST) begin
            state_d = CR_Y;
            // With X low the minimum is already met, so only X high marks a timeout.
            cr_tmo_d = X;
          end
        end
        CR_Y: if (timer_q == YEL_LAST)         state_d = AR2;
        AR2:  if (timer_q == RED_LAST)         state_d = HW_G;
        FLASH: begin
          if (!flash) begin
            state_d = AR2;
            phase_d = 1'b0;
          end else if (timer_q == FLASH_LAST) begin
            phase_d = ~phase_q;
            timer_d = '0;
          end
        end
        default: state_d = AR2;
      endcase
    end

    if (clear || state_d != state_q) timer_d = '0;
  end

  // Lamp decode depends only on registered state and phase.
  always_comb begin
    hw_lamp = LAMP_RED;
    cr_lamp = LAMP_RED;
    unique case (state_q)
      HW_G:  hw_lamp = LAMP_GRN;
      HW_Y:  hw_lamp = LAMP_YEL;
      CR_G:  cr_lamp = LAMP_GRN;
      CR_Y:  cr_lamp = LAMP_YEL;
      FLASH: begin
        hw_lamp = phase_q ? LAMP_OFF : LAMP_YEL;
        cr_lamp = phase_q ? LAMP_OFF : LAMP_RED;
      end
      default: ;
    endcase
  end

  assign HW     = hw_lamp;
  assign CR     = cr_lamp;
  assign state  = state_q;
  assign cr_tmo = cr_tmo_q;

  // Never show GREEN/YELLOW on both roads, and the timeout pulse only accompanies CR_Y.
  a_no_conflict: assert property (@(posedge clk) disable iff (clear)
    !((HW == LAMP_GRN || HW == LAMP_YEL) && (CR == LAMP_GRN || CR == LAMP_YEL)));
  a_tmo_in_cr_y: assert property (@(posedge clk) disable iff (clear)
    cr_tmo |-> state_q == CR_Y);

endmodule
